// File: rtl/uart_tx_scheduler.sv
// TX scheduler: THR FIFO/holding register in front of uart_transmitter.
// Ports: CLK/RST, WE/WDATA write port, FIFOEN/CLEAR control,
//   TXFINISHED in, TXSTART/DOUT to transmitter,
//   THRE/TEMT/LEVEL/OVERFLOW/THRI status.
module uart_tx_scheduler #(
    parameter  int DEPTH = 16,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          WE,
    input  logic [7:0]    WDATA,
    input  logic          FIFOEN,
    input  logic          CLEAR,
    input  logic          TXFINISHED,
    output logic          TXSTART,
    output logic [7:0]    DOUT,
    output logic          THRE,
    output logic          TEMT,
    output logic [LW-1:0] LEVEL,
    output logic          OVERFLOW,
    output logic          THRI
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t          state;
    state_t          state_d;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [LW-1:0]   level;
    logic [LW-1:0]   cap;
    logic [7:0]      dout_q;
    logic            fifoen_q;
    logic            ovf_q;
    logic            thre_q;
    logic            thri_q;
    logic            flush;
    logic            pop;
    logic            push;
    logic            empty;

    assign empty = (level == '0);
    assign cap   = FIFOEN ? LW'(DEPTH) : LW'(1);

    // A mode change empties the buffer exactly like CLEAR.
    assign flush = CLEAR | (FIFOEN ^ fifoen_q);

    // Pop loads the next byte: from IDLE at once, from SEND
    // only when the current frame reaches its stop state.
    assign pop = !empty && !flush &&
                 ((state == IDLE) || TXFINISHED);

    // A full buffer still takes a byte if one leaves now.
    assign push = WE && !flush && ((level < cap) || pop);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (pop) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (TXFINISHED && !pop) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        TXSTART = (state == SEND);
        TEMT    = empty && (state == IDLE);
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[tail] <= WDATA;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            head     <= '0;
            tail     <= '0;
            level    <= '0;
            dout_q   <= 8'h00;
            fifoen_q <= 1'b0;
            ovf_q    <= 1'b0;
            thre_q   <= 1'b1;
            thri_q   <= 1'b0;
        end else begin
            fifoen_q <= FIFOEN;
            ovf_q    <= WE && !flush && !push;
            thre_q   <= empty;
            thri_q   <= empty && !thre_q;
            if (pop) begin
                dout_q <= mem[head];
            end
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                level <= '0;
            end else begin
                if (pop) begin
                    head <= head + 1'b1;
                end
                if (push) begin
                    tail <= tail + 1'b1;
                end
                level <= level + LW'(push) - LW'(pop);
            end
        end
    end

    assign DOUT     = dout_q;
    assign THRE     = empty;
    assign LEVEL    = level;
    assign OVERFLOW = ovf_q;
    assign THRI     = thri_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Testbench for uart_tx_scheduler: queue-based reference model,
// per-cycle compare, directed scenarios and random traffic.
module tb_uart_tx_scheduler;

    localparam int DEPTH = 16;
    localparam int LW    = 5;

    logic          CLK = 1'b0;
    logic          RST;
    logic          WE;
    logic [7:0]    WDATA;
    logic          FIFOEN;
    logic          CLEAR;
    logic          TXFINISHED;
    logic          TXSTART;
    logic [7:0]    DOUT;
    logic          THRE;
    logic          TEMT;
    logic [LW-1:0] LEVEL;
    logic          OVERFLOW;
    logic          THRI;

    uart_tx_scheduler #(.DEPTH(DEPTH)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .WE         (WE),
        .WDATA      (WDATA),
        .FIFOEN     (FIFOEN),
        .CLEAR      (CLEAR),
        .TXFINISHED (TXFINISHED),
        .TXSTART    (TXSTART),
        .DOUT       (DOUT),
        .THRE       (THRE),
        .TEMT       (TEMT),
        .LEVEL      (LEVEL),
        .OVERFLOW   (OVERFLOW),
        .THRI       (THRI)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h",
                     name, act, exp);
        end
    endtask

    // Reference model: the buffer is a queue of bytes, m_busy
    // says a frame is on the wire.
    logic [7:0] q[$];
    bit         m_busy;
    logic [7:0] m_dout;
    bit         m_ovf;
    bit         m_thri;
    bit         m_pthre;
    bit         m_pfen;
    int         m_cap;
    bit         m_flush;
    bit         m_pop;
    bit         m_acc;

    task automatic model_step();
        if (RST) begin
            q.delete();
            m_busy  = 1'b0;
            m_dout  = 8'h00;
            m_ovf   = 1'b0;
            m_thri  = 1'b0;
            m_pthre = 1'b1;
            m_pfen  = 1'b0;
        end else begin
            m_cap   = FIFOEN ? DEPTH : 1;
            m_flush = CLEAR || (FIFOEN != m_pfen);
            m_pop   = (q.size() > 0) && !m_flush &&
                      (!m_busy || TXFINISHED);
            m_acc   = WE && !m_flush &&
                      ((q.size() < m_cap) || m_pop);
            m_ovf   = WE && !m_flush && !m_acc;
            m_thri  = (q.size() == 0) && !m_pthre;
            m_pthre = (q.size() == 0);
            m_pfen  = FIFOEN;
            if (m_pop) begin
                m_dout = q.pop_front();
                m_busy = 1'b1;
            end else if (m_busy && TXFINISHED) begin
                m_busy = 1'b0;
            end
            if (m_flush) q.delete();
            if (m_acc) q.push_back(WDATA);
        end
    endtask

    always @(posedge CLK or posedge RST) model_step();

    logic [17:0] act_v;
    logic [17:0] exp_v;

    always @(negedge CLK) begin
        if (!RST && cmp_en) begin
            act_v = {TXSTART, DOUT, LEVEL, THRE,
                     TEMT, OVERFLOW, THRI};
            exp_v = {m_busy, m_dout, LW'(q.size()),
                     q.size() == 0,
                     (q.size() == 0) && !m_busy,
                     m_ovf, m_thri};
            chk("cycle_outputs", int'(act_v), int'(exp_v));
            chk("level_max", int'(LEVEL <= 5'd16), 1);
        end
    end

    task automatic drive(bit we, logic [7:0] d,
                         bit fin, bit clr);
        WE         = we;
        WDATA      = d;
        TXFINISHED = fin;
        CLEAR      = clr;
        @(posedge CLK);
        @(negedge CLK);
        WE         = 1'b0;
        TXFINISHED = 1'b0;
        CLEAR      = 1'b0;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(0, 8'h00, 0, 0);
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, "_txstart"}, int'(TXSTART), 0);
        chk({tag, "_dout"}, int'(DOUT), 0);
        chk({tag, "_level"}, int'(LEVEL), 0);
        chk({tag, "_thre"}, int'(THRE), 1);
        chk({tag, "_temt"}, int'(TEMT), 1);
        chk({tag, "_ovf"}, int'(OVERFLOW), 0);
        chk({tag, "_thri"}, int'(THRI), 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (m_busy || q.size() > 0);
             i++) begin
            drive(0, 8'h00, 1, 0);
            idle(1);
        end
        chk("drain_idle", int'(TEMT), 1);
    endtask

    initial begin
        RST        = 1'b1;
        WE         = 1'b0;
        WDATA      = 8'h00;
        FIFOEN     = 1'b1;
        CLEAR      = 1'b0;
        TXFINISHED = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        #1;
        chk_reset_vals("reset");
        cmp_en = 1'b1;
        @(negedge CLK);
        idle(2);

        // single byte
        drive(1, 8'hA5, 0, 0);
        chk("sb_level_n1", int'(LEVEL), 1);
        chk("sb_thre_n1", int'(THRE), 0);
        chk("sb_temt_n1", int'(TEMT), 0);
        idle(1);
        chk("sb_dout_n2", int'(DOUT), 'hA5);
        chk("sb_txstart_n2", int'(TXSTART), 1);
        chk("sb_level_n2", int'(LEVEL), 0);
        chk("sb_thre_n2", int'(THRE), 1);
        idle(1);
        chk("sb_thri_n3", int'(THRI), 1);
        drive(0, 8'h00, 1, 0);
        chk("sb_txstart_end", int'(TXSTART), 0);
        chk("sb_temt_end", int'(TEMT), 1);
        idle(2);

        // burst of 17 while sending
        drive(1, 8'hEE, 0, 0);
        idle(1);
        chk("burst_pre_dout", int'(DOUT), 'hEE);
        for (int k = 1; k <= 17; k++) begin
            drive(1, 8'(k), 0, 0);
            if (k == 16)
                chk("burst_level16", int'(LEVEL), 16);
        end
        chk("burst_ovf", int'(OVERFLOW), 1);
        chk("burst_level_held", int'(LEVEL), 16);
        idle(1);
        chk("burst_ovf_once", int'(OVERFLOW), 0);
        for (int k = 1; k <= 16; k++) begin
            drive(0, 8'h00, 1, 0);
            chk("burst_dout_order", int'(DOUT), k);
            idle(2);
        end
        drive(0, 8'h00, 1, 0);
        chk("burst_done_temt", int'(TEMT), 1);
        idle(1);

        // holding-register mode
        FIFOEN = 1'b0;
        idle(2);
        drive(1, 8'h10, 0, 0);
        idle(1);
        chk("nf_dout", int'(DOUT), 'h10);
        drive(1, 8'h20, 0, 0);
        chk("nf_second_acc", int'(LEVEL), 1);
        chk("nf_second_ovf", int'(OVERFLOW), 0);
        drive(1, 8'h40, 0, 0);
        chk("nf_third_ovf", int'(OVERFLOW), 1);
        FIFOEN = 1'b1;
        idle(1);
        chk("nf_toggle_level", int'(LEVEL), 0);
        chk("nf_toggle_dout", int'(DOUT), 'h10);
        drain();
        idle(1);

        // wrap-around interleaving
        for (int i = 0; i < 40; i++) begin
            drive(($urandom % 4) != 0, 8'($urandom),
                  m_busy && ($urandom % 2 == 0), 0);
        end
        drain();
        idle(1);

        // clear mid-frame with five buffered
        for (int k = 0; k < 6; k++) drive(1, 8'(8'h60 + k), 0, 0);
        chk("clr_pre_level", int'(LEVEL), 5);
        chk("clr_pre_dout", int'(DOUT), 'h60);
        drive(1, 8'h77, 0, 1);
        chk("clr_level", int'(LEVEL), 0);
        chk("clr_dout", int'(DOUT), 'h60);
        chk("clr_txstart", int'(TXSTART), 1);
        chk("clr_we_no_ovf", int'(OVERFLOW), 0);
        idle(1);
        chk("clr_thri", int'(THRI), 1);
        drive(0, 8'h00, 1, 0);
        chk("clr_idle_txstart", int'(TXSTART), 0);
        chk("clr_idle_temt", int'(TEMT), 1);
        idle(1);

        // reset mid-frame
        for (int k = 0; k < 4; k++) drive(1, 8'(8'hC0 + k), 0, 0);
        chk("rst_pre_level", int'(LEVEL), 3);
        chk("rst_pre_txstart", int'(TXSTART), 1);
        RST = 1'b1;
        #1;
        chk_reset_vals("rst_mid");
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("rst_no_thri", int'(THRI), 0);
        end

        // random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom % 64 == 0) FIFOEN = ~FIFOEN;
            drive(($urandom % 2) == 0, 8'($urandom),
                  ($urandom % 3) == 0,
                  ($urandom % 32) == 0);
        end
        FIFOEN = 1'b1;
        idle(2);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
